// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480 timing, FIFO sizing and
// the PPU pixel byte layout shared by the scanout block.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP
                              + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP
                              + VGA_V_SYNC + VGA_V_BP;

  localparam logic VGA_HS_POL = 1'b0;
  localparam logic VGA_VS_POL = 1'b0;

  localparam int VGA_HSCALE     = 4;
  localparam int VGA_FIFO_DEPTH = 16;

  localparam int R_LSB = 6;
  localparam int G_LSB = 4;
  localparam int B_LSB = 2;

  // Field order mirrors R_LSB/G_LSB/B_LSB; pad is never shown.
  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic [1:0] pad;
  } pix_t;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_scanout_if.sv
// vga_scanout_if: PPU byte stream into the scanout,
// stb held by the producer until the one-cycle ack.
interface vga_scanout_if;

  logic [7:0] in_data;
  logic       in_stb;
  logic       in_ack;

  modport master (
    output in_data,
    output in_stb,
    input  in_ack
  );

  modport slave (
    input  in_data,
    input  in_stb,
    output in_ack
  );

endinterface

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous FIFO, combinational read of head,
// pushes on full and pops on empty are ignored.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: buffers the PPU byte stream and scans it out
// as VGA with HSCALE-wide pixels and a per-frame PPU sync.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE   = VGA_H_ACTIVE,
  parameter int   H_FP       = VGA_H_FP,
  parameter int   H_SYNC     = VGA_H_SYNC,
  parameter int   H_BP       = VGA_H_BP,
  parameter int   V_ACTIVE   = VGA_V_ACTIVE,
  parameter int   V_FP       = VGA_V_FP,
  parameter int   V_SYNC     = VGA_V_SYNC,
  parameter int   V_BP       = VGA_V_BP,
  parameter logic HS_POL     = VGA_HS_POL,
  parameter logic VS_POL     = VGA_VS_POL,
  parameter int   HSCALE     = VGA_HSCALE,
  parameter int   FIFO_DEPTH = VGA_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  vga_scanout_if.slave pix,
  input  logic       clr_uflow,
  output logic       frame_sync,
  output logic [1:0] vga_r,
  output logic [1:0] vga_g,
  output logic [1:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       active,
  output logic       underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int RW = (HSCALE > 1) ? $clog2(HSCALE) : 1;

  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [RW-1:0] rep;

  logic       h_end;
  logic       v_end;
  logic       vis;
  logic       fetch;
  logic       pop;
  logic       accept;
  logic       hs_on;
  logic       vs_on;
  logic       full;
  logic       empty;
  logic [7:0] rd_byte;
  pix_t       rd;
  rgb_t       rgb;
  logic       pad_unused;

  assign h_end = hcnt == HW'(H_TOTAL - 1);
  assign v_end = vcnt == VW'(V_TOTAL - 1);

  assign vis = (hcnt < HW'(H_ACTIVE))
            && (vcnt < VW'(V_ACTIVE));

  assign fetch  = vis && (rep == '0);
  assign pop    = fetch && !empty;

  // Blocking on in_ack keeps a held stb from writing twice.
  assign accept = pix.in_stb && !full && !pix.in_ack;

  assign hs_on = (hcnt >= HW'(HS_BEG))
              && (hcnt < HW'(HS_END));
  assign vs_on = (vcnt >= VW'(VS_BEG))
              && (vcnt < VW'(VS_END));

  assign rd         = pix_t'(rd_byte);
  assign pad_unused = ^rd.pad;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .wdata (pix.in_data),
    .rdata (rd_byte),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
      rep  <= '0;
    end else begin
      hcnt <= h_end ? '0 : hcnt + HW'(1);
      if (h_end) begin
        vcnt <= v_end ? '0 : vcnt + VW'(1);
      end
      if (vis && rep != RW'(HSCALE - 1)) begin
        rep <= rep + RW'(1);
      end else begin
        rep <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix.in_ack <= 1'b0;
      frame_sync <= 1'b0;
      rgb        <= '0;
      active     <= 1'b0;
      underflow  <= 1'b0;
      vga_hs     <= ~HS_POL;
      vga_vs     <= ~VS_POL;
    end else begin
      pix.in_ack <= accept;
      frame_sync <= (hcnt == '0)
                 && (vcnt == VW'(V_ACTIVE));
      active     <= vis;
      vga_hs     <= hs_on ? HS_POL : ~HS_POL;
      vga_vs     <= vs_on ? VS_POL : ~VS_POL;
      unique case (1'b1)
        !vis:            rgb <= '0;
        pop:             rgb <= '{r: rd.r,
                                  g: rd.g,
                                  b: rd.b};
        fetch && empty:  rgb <= '0;
        default:         rgb <= rgb;
      endcase
      if (clr_uflow) begin
        underflow <= 1'b0;
      end else if (fetch && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  assign vga_r = rgb.r;
  assign vga_g = rgb.g;
  assign vga_b = rgb.b;

endmodule
